// File: rtl/conv2_scheduler.sv
// -----------------------------------------------------------------------------
// conv2_scheduler
//   Walks the layer-2 convolution engine over every output position and output
//   channel (column fastest, then row, then channel). For each position it
//   pulses the engine, waits for the result and writes it to the output
//   feature-map buffer.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         sweep request, accepted only in IDLE
//   abort         abandon the sweep and return to IDLE (no done pulse)
//   busy          high while a position is being issued, awaited or written
//   done          one-cycle pulse when the last position has been written
//   err           sticky flag: eng_done seen while not waiting for the engine
//   eng_start     one-cycle pulse asking the engine to compute (row,col,ch)
//   eng_done      one-cycle engine result strobe
//   row/col/ch    current output position, stable from ISSUE through WRITE
//   wr_en         output buffer write request
//   wr_ready      buffer accepts the write this cycle
//   wr_addr       ch*OUT_ROWS*OUT_COLS + row*OUT_COLS + col
//   state_dbg     current FSM state, for checkers
//
// Write handshake: a write transfers on any cycle where wr_en && wr_ready.
// Once wr_en rises it stays high, with wr_addr and row/col/ch held constant,
// until that transfer happens (or abort/rst). wr_ready may toggle freely.
// -----------------------------------------------------------------------------
module conv2_scheduler #(
    parameter int OUT_ROWS = 28,
    parameter int OUT_COLS = 28,
    parameter int NUM_CH   = 16,
    parameter int ADDR_W   = 14,
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1,
    localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1,
    localparam int HW = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              eng_start,
    input  logic              eng_done,
    output logic [RW-1:0]     row,
    output logic [CW-1:0]     col,
    output logic [HW-1:0]     ch,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [RW-1:0]       row_nxt;
    logic [CW-1:0]       col_nxt;
    logic [HW-1:0]       ch_nxt;
    logic [ADDR_W-1:0]   wr_addr_nxt;
    logic                err_nxt;

    logic last_col, last_row, last_ch;

    assign last_col  = (col == CW'(OUT_COLS - 1));
    assign last_row  = (row == RW'(OUT_ROWS - 1));
    assign last_ch   = (ch  == HW'(NUM_CH - 1));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            ch      <= '0;
            wr_addr <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            row     <= row_nxt;
            col     <= col_nxt;
            ch      <= ch_nxt;
            wr_addr <= wr_addr_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;
        ch_nxt      = ch;
        wr_addr_nxt = wr_addr;
        err_nxt     = err;
        busy        = 1'b0;
        done        = 1'b0;
        eng_start   = 1'b0;
        wr_en       = 1'b0;

        if (abort && (state != S_IDLE)) begin
            // Abandon: indices cleared, err left exactly as it was.
            state_nxt   = S_IDLE;
            row_nxt     = '0;
            col_nxt     = '0;
            ch_nxt      = '0;
            wr_addr_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row_nxt     = '0;
                        col_nxt     = '0;
                        ch_nxt      = '0;
                        wr_addr_nxt = '0;
                        err_nxt     = 1'b0;
                        state_nxt   = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    busy      = 1'b1;
                    eng_start = 1'b1;
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    busy = 1'b1;
                    if (eng_done) begin
                        state_nxt = S_WRITE;
                    end
                end
                S_WRITE: begin
                    busy  = 1'b1;
                    wr_en = 1'b1;
                    if (wr_ready) begin
                        if (last_col && last_row && last_ch) begin
                            state_nxt = S_DONE;
                        end else begin
                            // The sweep order matches the address layout, so
                            // the next address is always the current one + 1.
                            wr_addr_nxt = wr_addr + ADDR_W'(1);
                            state_nxt   = S_ISSUE;
                            if (!last_col) begin
                                col_nxt = col + CW'(1);
                            end else begin
                                col_nxt = '0;
                                if (!last_row) begin
                                    row_nxt = row + RW'(1);
                                end else begin
                                    row_nxt = '0;
                                    ch_nxt  = ch + HW'(1);
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase

            // A stray engine strobe is flagged even on the cycle a start is
            // accepted, so it is applied after the start clear.
            if (eng_done && (state != S_WAIT)) begin
                err_nxt = 1'b1;
            end
        end
    end

endmodule
